max_pool_pipe: RTL and testbench

MAX_POOL_PIPE -- requirements
Module: max_pool_pipe

---
 rtl/mannix_pool_pkg.sv | 22 ++
 rtl/max_pool_pipe_if.sv | 24 ++
 rtl/max_node.sv | 52 +++++
 rtl/max_pool_pipe.sv | 150 +++++++++++++++
 tb/tb_max_pool_pipe.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mannix_pool_pkg.sv
// Shared types, index width and the compare helper used by every max_pool_pipe stage.
package mannix_pool_pkg;

  localparam int IDX_W  = 16;
  localparam int MAX_DW = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } acc_state_e;

  // Two's-complement order equals unsigned order once the sign bit is inverted.
  function automatic logic val_gt(input logic [MAX_DW-1:0] a,
                                  input logic [MAX_DW-1:0] b,
                                  input int unsigned       dw,
                                  input logic              sgn);
    logic [MAX_DW-1:0] flip;
    flip = sgn ? (MAX_DW'(1) << (dw - 1)) : '0;
    return (a ^ flip) > (b ^ flip);
  endfunction

endpackage

// File: rtl/max_pool_pipe_if.sv
// Beat input stream and window-result output stream of max_pool_pipe.
interface max_pool_pipe_if #(
  parameter int DW = 8,
  parameter int N  = 8
);
  logic                               in_valid;
  logic                               in_ready;
  logic [N*DW-1:0]                    in_data;
  logic                               in_last;
  logic                               out_valid;
  logic                               out_ready;
  logic [DW-1:0]                      out_max;
  logic [mannix_pool_pkg::IDX_W-1:0]  out_idx;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_idx
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_idx
  );
endinterface

// File: rtl/max_node.sv
// One registered compare-select, 1 cycle, holds when en_i is low; b wins only if strictly greater.
// Index ports and register exist only with MAX_POOL_PIPE_ARGMAX_EN defined.
module max_node
  import mannix_pool_pkg::*;
#(
  parameter int DW     = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DW-1:0]    a_val_i,
  input  logic [DW-1:0]    b_val_i,
`ifdef MAX_POOL_PIPE_ARGMAX_EN
  input  logic [IDX_W-1:0] a_idx_i,
  input  logic [IDX_W-1:0] b_idx_i,
  output logic [IDX_W-1:0] idx_o,
`endif
  output logic [DW-1:0]    val_o
);
  localparam logic SGN = (SIGNED != 0);

  logic          b_wins;
  logic [DW-1:0] val_q;

  assign b_wins = val_gt(MAX_DW'(b_val_i), MAX_DW'(a_val_i), DW, SGN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
    end else if (en_i) begin
      val_q <= b_wins ? b_val_i : a_val_i;
    end
  end

  assign val_o = val_q;

`ifdef MAX_POOL_PIPE_ARGMAX_EN
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (en_i) begin
      idx_q <= b_wins ? b_idx_i : a_idx_i;
    end
  end

  assign idx_o = idx_q;
`endif

endmodule

// File: rtl/max_pool_pipe.sv
// Windowed max over N-lane beats: log2(N) compare levels + accumulate stage, latency log2(N)+1, one beat/cycle.
// Whole pipe holds while out_valid && !out_ready; argmax index only with MAX_POOL_PIPE_ARGMAX_EN defined.
module max_pool_pipe
  import mannix_pool_pkg::*;
#(
  parameter int DW     = 8,
  parameter int N      = 8,
  parameter int SIGNED = 0
) (
  input logic            clk,
  input logic            rst_n,
  max_pool_pipe_if.slave pool
);
  localparam int   LG  = $clog2(N);
  localparam int   CW  = IDX_W - LG;
  localparam logic SGN = (SIGNED != 0);

  logic          adv;
  logic [LG:1]   vld_q;
  logic [LG:1]   last_q;
  logic [DW-1:0] tv [1:2*N-1];
  logic          root_vld;
  logic          root_last;
  logic          take_root;
  logic [DW-1:0] merge_max_d;
  acc_state_e    state_q;
  logic [DW-1:0] acc_max_q;
  logic [DW-1:0] out_max_q;
  logic          out_vld_q;

`ifdef MAX_POOL_PIPE_ARGMAX_EN
  logic             accept;
  logic [IDX_W-1:0] ti [1:2*N-1];
  logic [CW-1:0]    beat_q;
  logic [IDX_W-1:0] merge_idx_d;
  logic [IDX_W-1:0] acc_idx_q;
  logic [IDX_W-1:0] out_idx_q;
`endif

  assign adv           = !(out_vld_q && !pool.out_ready);
  assign pool.in_ready = adv;

  // Heap layout: node i has children 2i (lower lanes) and 2i+1; leaves N..2N-1 are lanes 0..N-1.
  for (genvar k = 0; k < N; k++) begin : g_leaf
    assign tv[N+k] = pool.in_data[k*DW +: DW];
`ifdef MAX_POOL_PIPE_ARGMAX_EN
    assign ti[N+k] = {beat_q, LG'(k)};
`endif
  end

  for (genvar i = 1; i < N; i++) begin : g_node
    max_node #(
      .DW     (DW),
      .SIGNED (SIGNED)
    ) u_node (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (adv),
      .a_val_i (tv[2*i]),
      .b_val_i (tv[2*i+1]),
`ifdef MAX_POOL_PIPE_ARGMAX_EN
      .a_idx_i (ti[2*i]),
      .b_idx_i (ti[2*i+1]),
      .idx_o   (ti[i]),
`endif
      .val_o   (tv[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
    end else if (adv) begin
      vld_q[1]  <= pool.in_valid;
      last_q[1] <= pool.in_valid && pool.in_last;
      for (int l = 2; l <= LG; l++) begin
        vld_q[l]  <= vld_q[l-1];
        last_q[l] <= last_q[l-1];
      end
    end
  end

  assign root_vld  = vld_q[LG];
  assign root_last = last_q[LG];

  // Accumulator holds earlier beats, so the tree result must be strictly greater to replace it.
  assign take_root   = (state_q == ST_IDLE) ||
                       val_gt(MAX_DW'(tv[1]), MAX_DW'(acc_max_q), DW, SGN);
  assign merge_max_d = take_root ? tv[1] : acc_max_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_max_q <= '0;
      out_max_q <= '0;
      out_vld_q <= 1'b0;
    end else if (adv) begin
      out_vld_q <= root_vld && root_last;
      if (root_vld) begin
        if (root_last) begin
          state_q   <= ST_IDLE;
          out_max_q <= merge_max_d;
        end else begin
          state_q   <= ST_RUN;
          acc_max_q <= merge_max_d;
        end
      end
    end
  end

  assign pool.out_valid = out_vld_q;
  assign pool.out_max   = out_max_q;

`ifdef MAX_POOL_PIPE_ARGMAX_EN
  assign accept      = pool.in_valid && adv;
  assign merge_idx_d = take_root ? ti[1] : acc_idx_q;

  // Beat number saturates; later beats share the last index but still compete on value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else if (accept) begin
      if (pool.in_last) begin
        beat_q <= '0;
      end else if (!(&beat_q)) begin
        beat_q <= beat_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_idx_q <= '0;
      out_idx_q <= '0;
    end else if (adv && root_vld) begin
      if (root_last) begin
        out_idx_q <= merge_idx_d;
      end else begin
        acc_idx_q <= merge_idx_d;
      end
    end
  end

  assign pool.out_idx = out_idx_q;
`else
  assign pool.out_idx = '0;
`endif

endmodule

// File: tb/tb_max_pool_pipe.sv
// Randomised and directed checks of max_pool_pipe (unsigned and signed instances) against a window-level model.
module tb_max_pool_pipe;
  localparam int DW   = 8;
  localparam int N    = 8;
  localparam int LG   = 3;
  localparam int BMAX = (1 << (16 - LG)) - 1;
`ifdef MAX_POOL_PIPE_ARGMAX_EN
  localparam bit ARG = 1'b1;
`else
  localparam bit ARG = 1'b0;
`endif

  typedef logic [DW-1:0]   lane_t;
  typedef logic [N*DW-1:0] beat_t;
  typedef struct {
    lane_t umax;
    int    uidx;
    lane_t smax;
    int    sidx;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  max_pool_pipe_if #(.DW(DW), .N(N)) bu ();
  max_pool_pipe_if #(.DW(DW), .N(N)) bs ();

  max_pool_pipe #(.DW(DW), .N(N), .SIGNED(0)) dut_u (.clk(clk), .rst_n(rst_n), .pool(bu));
  max_pool_pipe #(.DW(DW), .N(N), .SIGNED(1)) dut_s (.clk(clk), .rst_n(rst_n), .pool(bs));

  int    n_vec = 0;
  int    n_err = 0;
  int    rdy_pct = 100;
  int    hold_low = 0;
  int    max_tries = 0;
  logic  prev_stall = 1'b0;
  lane_t prev_max;
  logic [15:0] prev_idx;

  beat_t win_q[$];
  exp_t  exp_u[$];
  exp_t  exp_s[$];
  lane_t hist_umax[$];
  lane_t hist_smax[$];
  int    hist_uidx[$];
  int    hist_sidx[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t pack(input lane_t lv [N]);
    beat_t b;
    for (int k = 0; k < N; k++) b[k*DW +: DW] = lv[k];
    return b;
  endfunction

  // Scan the whole window beat by beat, lane by lane; only a strictly larger value moves the winner.
  function automatic exp_t ref_window();
    exp_t  e;
    beat_t bb;
    lane_t v;
    int    bi;
    e = '{umax: '0, uidx: 0, smax: '0, sidx: 0};
    for (int b = 0; b < win_q.size(); b++) begin
      bb = win_q[b];
      bi = (b > BMAX) ? BMAX : b;
      for (int k = 0; k < N; k++) begin
        v = bb[k*DW +: DW];
        if (b == 0 && k == 0 || v > e.umax) begin
          e.umax = v;
          e.uidx = bi * N + k;
        end
        if (b == 0 && k == 0 || $signed(v) > $signed(e.smax)) begin
          e.smax = v;
          e.sidx = bi * N + k;
        end
      end
    end
    return e;
  endfunction

  task automatic drive(input logic v, input beat_t d, input logic l, input logic r);
    bu.in_valid = v; bu.in_data = d; bu.in_last = l; bu.out_ready = r;
    bs.in_valid = v; bs.in_data = d; bs.in_last = l; bs.out_ready = r;
  endtask

  task automatic step(input logic v, input beat_t d, input logic l, output logic taken);
    logic ordy;
    exp_t e;
    if (hold_low > 0) begin
      ordy = 1'b0;
      hold_low--;
    end else begin
      ordy = ($urandom_range(99) < rdy_pct);
    end
    @(negedge clk);
    drive(v, d, l, ordy);
    #1;
    if (prev_stall) begin
      check("hold_vld", bu.out_valid, 1'b1);
      check("hold_max", bu.out_max, prev_max);
      check("hold_idx", bu.out_idx, prev_idx);
    end
    check("in_ready_u", bu.in_ready, !(bu.out_valid && !bu.out_ready));
    check("in_ready_s", bs.in_ready, !(bs.out_valid && !bs.out_ready));
    prev_stall = bu.out_valid && !bu.out_ready;
    prev_max   = bu.out_max;
    prev_idx   = bu.out_idx;
    if (bu.out_valid && bu.out_ready) begin
      if (exp_u.size() == 0) begin
        check("u_spurious", exp_u.size(), 1);
      end else begin
        e = exp_u.pop_front();
        check("u_max", bu.out_max, e.umax);
        check("u_idx", bu.out_idx, ARG ? e.uidx : 0);
      end
      hist_umax.push_back(bu.out_max);
      hist_uidx.push_back(int'(bu.out_idx));
    end
    if (bs.out_valid && bs.out_ready) begin
      if (exp_s.size() == 0) begin
        check("s_spurious", exp_s.size(), 1);
      end else begin
        e = exp_s.pop_front();
        check("s_max", bs.out_max, e.smax);
        check("s_idx", bs.out_idx, ARG ? e.sidx : 0);
      end
      hist_smax.push_back(bs.out_max);
      hist_sidx.push_back(int'(bs.out_idx));
    end
    taken = v && bu.in_ready;
    if (taken) begin
      win_q.push_back(d);
      if (l) begin
        e = ref_window();
        exp_u.push_back(e);
        exp_s.push_back(e);
        win_q.delete();
      end
    end
  endtask

  task automatic send_beat(input beat_t d, input logic l, output int tries);
    logic t;
    t = 1'b0;
    tries = 0;
    while (!t && tries < 64) begin
      step(1'b1, d, l, t);
      tries++;
    end
    if (tries > max_tries) max_tries = tries;
    if (!t) check("accept_bound", t, 1'b1);
  endtask

  task automatic drain();
    logic t;
    for (int i = 0; i < 300 && (exp_u.size() + exp_s.size()) > 0; i++) step(1'b0, '0, 1'b0, t);
    check("drain_u", exp_u.size(), 0);
    check("drain_s", exp_s.size(), 0);
  endtask

  initial begin
    logic  t;
    int    tries, base, lat, len;
    bit    tie;
    lane_t lv [N];

    drive(1'b0, '0, 1'b0, 1'b1);
    #1;
    check("rst_out_valid", bu.out_valid, 1'b0);
    check("rst_out_max", bu.out_max, 0);
    check("rst_out_idx", bu.out_idx, 0);
    check("rst_in_ready", bu.in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single beat: latency and tie to lower lane.
    rdy_pct = 100;
    repeat (2) step(1'b0, '0, 1'b0, t);
    base = hist_umax.size();
    lv = '{8'd3, 8'd9, 8'd1, 8'd9, 8'd0, 8'd2, 8'd7, 8'd5};
    send_beat(pack(lv), 1'b1, tries);
    lat = 0;
    t = 1'b0;
    while (!t && lat < 20) begin
      step(1'b0, '0, 1'b0, t);
      lat++;
      t = bu.out_valid;
    end
    check("latency", lat, 4);
    check("r31_max", hist_umax[base], 8'd9);
    check("r31_idx", hist_uidx[base], ARG ? 1 : 0);
    check("r31_smax", hist_smax[base], 8'd9);

    // Three-beat window then an immediate follow-on window.
    base = hist_umax.size();
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < N; k++) lv[k] = lane_t'($urandom_range(8'hEF));
      if (b == 2) lv[6] = 8'hF0;
      send_beat(pack(lv), b == 2, tries);
    end
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < N; k++) lv[k] = lane_t'($urandom);
      send_beat(pack(lv), b == 1, tries);
      check("b2b_tries", tries, 1);
    end
    drain();
    check("r32_max", hist_umax[base], 8'hF0);
    check("r32_idx", hist_uidx[base], ARG ? 22 : 0);

    // Signed versus unsigned ordering.
    base = hist_umax.size();
    lv = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40};
    send_beat(pack(lv), 1'b1, tries);
    drain();
    check("r33_umax", hist_umax[base], 8'hFF);
    check("r33_uidx", hist_uidx[base], ARG ? 2 : 0);
    check("r33_smax", hist_smax[base], 8'h7F);
    check("r33_sidx", hist_sidx[base], ARG ? 1 : 0);

    // Output held off for several cycles while more beats are offered.
    base = hist_umax.size();
    max_tries = 0;
    for (int k = 0; k < N; k++) lv[k] = lane_t'($urandom);
    send_beat(pack(lv), 1'b1, tries);
    hold_low = 8;
    for (int w = 0; w < 3; w++) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) lv[k] = lane_t'($urandom);
        send_beat(pack(lv), b == 1, tries);
      end
    end
    check("stall_backpressure", max_tries >= 4, 1'b1);
    drain();
    check("stall_results", hist_umax.size() - base, 4);

    // Reset in the middle of a window with a result parked at the output.
    for (int k = 0; k < N; k++) lv[k] = 8'hFF;
    send_beat(pack(lv), 1'b1, tries);
    hold_low = 100;
    send_beat(pack(lv), 1'b0, tries);
    send_beat(pack(lv), 1'b0, tries);
    repeat (2) step(1'b0, '0, 1'b0, t);
    check("pre_rst_valid", bu.out_valid, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bu.out_valid, 1'b0);
    check("mid_rst_in_ready", bu.in_ready, 1'b1);
    win_q.delete();
    exp_u.delete();
    exp_s.delete();
    prev_stall = 1'b0;
    hold_low = 0;
    @(negedge clk);
    rst_n = 1'b1;
    base = hist_umax.size();
    lv = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h40, 8'h06, 8'h07};
    send_beat(pack(lv), 1'b1, tries);
    drain();
    check("post_rst_results", hist_umax.size() - base, 1);
    check("post_rst_max", hist_umax[base], 8'h40);
    check("post_rst_idx", hist_uidx[base], ARG ? 5 : 0);

    // Random windows, bubbles and backpressure.
    rdy_pct = 70;
    for (int w = 0; w < 200; w++) begin
      len = $urandom_range(4, 1);
      tie = 1'($urandom_range(1));
      for (int b = 0; b < len; b++) begin
        for (int k = 0; k < N; k++) lv[k] = tie ? lane_t'($urandom_range(3)) : lane_t'($urandom);
        if ($urandom_range(4) == 0) step(1'b0, '0, 1'b0, t);
        send_beat(pack(lv), b == len - 1, tries);
      end
    end
    rdy_pct = 100;
    drain();

    // Window long enough to saturate the beat counter.
    base = hist_umax.size();
    for (int b = 0; b < BMAX + 5; b++) begin
      for (int k = 0; k < N; k++) lv[k] = '0;
      if (b == BMAX + 3) lv[3] = 8'h55;
      send_beat(pack(lv), b == BMAX + 4, tries);
    end
    drain();
    check("sat_max", hist_umax[base], 8'h55);
    check("sat_idx", hist_uidx[base], ARG ? (BMAX * N + 3) : 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
